fetch_pc_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the G-share branch predictor. It owns the fetch PC register, drives the synchronous instruction memory, and applies the predictor's 2-bit PC select each cycle. It also holds the IF/ID pipeline register, which carries the PC, PC+4, the instruction and the predicted-taken flag to decode. The block handles ID stalls with a one-entry instruction hold buffer and handles mispredict flushes by inserting a single bubble.

---
 rtl/fetch_pc_unit_if.sv | 37 +++
 rtl/fetch_pc_unit.sv | 105 ++++++++++
 tb/tb_fetch_pc_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_unit_if
//  Brief    : Predictor, EX, ID and instruction-memory signals of the fetch stage
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_pc_unit_if;
   logic [1:0]  i_pc_sel;
   logic [31:0] i_alu_ex;
   logic [31:0] i_pc_four_ex;
   logic [31:0] i_pred_pc;
   logic        i_flush;
   logic        i_stall;
   logic [31:0] i_imem_rdata;
   logic [31:0] o_imem_addr;
   logic [31:0] o_pc_now;
   logic [31:0] o_pc_id;
   logic [31:0] o_pc_four_id;
   logic [31:0] o_instr_id;
   logic        o_valid_id;
   logic        o_pred_taken_id;
   logic [31:0] o_fetch_cnt;
   logic [15:0] o_redirect_cnt;

   modport master (
      output i_pc_sel, i_alu_ex, i_pc_four_ex, i_pred_pc, i_flush, i_stall, i_imem_rdata,
      input  o_imem_addr, o_pc_now, o_pc_id, o_pc_four_id, o_instr_id, o_valid_id,
             o_pred_taken_id, o_fetch_cnt, o_redirect_cnt
   );

   modport slave (
      input  i_pc_sel, i_alu_ex, i_pc_four_ex, i_pred_pc, i_flush, i_stall, i_imem_rdata,
      output o_imem_addr, o_pc_now, o_pc_id, o_pc_four_id, o_instr_id, o_valid_id,
             o_pred_taken_id, o_fetch_cnt, o_redirect_cnt
   );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_unit
//  Brief    : Fetch PC register, next-PC select, IF/ID register with stall hold
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   fetch_pc_unit_if.slave bus
);

   logic [31:0] pc_q,           pc_d;
   logic [31:0] id_pc_q,        id_pc_d;
   logic        id_valid_q,     id_valid_d;
   logic        id_pred_q,      id_pred_d;
   logic        hold_v_q,       hold_v_d;
   logic [31:0] hold_instr_q,   hold_instr_d;
   logic [31:0] fetch_cnt_q,    fetch_cnt_d;
   logic [15:0] redirect_cnt_q, redirect_cnt_d;
   logic [31:0] pc_mux;

   always_comb begin
      pc_mux = pc_q + 32'd4;
      case (bus.i_pc_sel)
         2'b00:   pc_mux = pc_q + 32'd4;
         2'b01:   pc_mux = bus.i_alu_ex;
         2'b10:   pc_mux = bus.i_pc_four_ex;
         default: pc_mux = bus.i_pred_pc;
      endcase
   end

   always_comb begin
      pc_d           = pc_q;
      id_pc_d        = id_pc_q;
      id_valid_d     = id_valid_q;
      id_pred_d      = id_pred_q;
      hold_v_d       = hold_v_q;
      hold_instr_d   = hold_instr_q;
      fetch_cnt_d    = fetch_cnt_q;
      redirect_cnt_d = redirect_cnt_q;
      if (bus.i_flush) begin
         pc_d       = pc_mux;
         id_valid_d = 1'b0;
         id_pred_d  = 1'b0;
         hold_v_d   = 1'b0;
         if (redirect_cnt_q != 16'hFFFF) begin
            redirect_cnt_d = redirect_cnt_q + 16'd1;
         end
      end else if (bus.i_stall) begin
         // Read data only matches the ID slot on the first stalled cycle; capture it then.
         if (!hold_v_q && id_valid_q) begin
            hold_v_d     = 1'b1;
            hold_instr_d = bus.i_imem_rdata;
         end
      end else begin
         pc_d       = pc_mux;
         id_pc_d    = pc_q;
         id_valid_d = 1'b1;
         id_pred_d  = (bus.i_pc_sel == 2'b11);
         hold_v_d   = 1'b0;
         if (id_valid_q) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc_q           <= RESET_PC;
         id_pc_q        <= 32'h0000_0000;
         id_valid_q     <= 1'b0;
         id_pred_q      <= 1'b0;
         hold_v_q       <= 1'b0;
         hold_instr_q   <= 32'h0000_0000;
         fetch_cnt_q    <= 32'h0000_0000;
         redirect_cnt_q <= 16'h0000;
      end else begin
         pc_q           <= pc_d;
         id_pc_q        <= id_pc_d;
         id_valid_q     <= id_valid_d;
         id_pred_q      <= id_pred_d;
         hold_v_q       <= hold_v_d;
         hold_instr_q   <= hold_instr_d;
         fetch_cnt_q    <= fetch_cnt_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   assign bus.o_imem_addr     = pc_q;
   assign bus.o_pc_now        = pc_q;
   assign bus.o_pc_id         = id_pc_q;
   assign bus.o_pc_four_id    = id_pc_q + 32'd4;
   assign bus.o_valid_id      = id_valid_q;
   assign bus.o_pred_taken_id = id_pred_q;
   assign bus.o_fetch_cnt     = fetch_cnt_q;
   assign bus.o_redirect_cnt  = redirect_cnt_q;
   assign bus.o_instr_id      = hold_v_q   ? hold_instr_q     :
                                id_valid_q ? bus.i_imem_rdata : NOP_INSTR;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_pc_unit
//  Brief    : Directed table, corner sequences and random run against a model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   fetch_pc_unit_if bus ();

   fetch_pc_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: one fixed marker word, hashed addresses elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0600) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   always @(posedge clk) bus.i_imem_rdata <= mem_word(bus.o_imem_addr);

   // Reference model: the ID slot always presents the word stored at its PC.
   logic [31:0] m_pc, m_id_pc, m_fetch;
   logic [15:0] m_red;
   logic        m_valid, m_pred;

   task automatic model_reset();
      m_pc = RST_PC; m_id_pc = 32'h0; m_valid = 1'b0; m_pred = 1'b0;
      m_fetch = 32'h0; m_red = 16'h0;
   endtask

   task automatic model_edge();
      logic [31:0] tgt;
      if (!rst_n) begin
         model_reset();
         return;
      end
      case (bus.i_pc_sel)
         2'd0: tgt = m_pc + 32'd4;
         2'd1: tgt = bus.i_alu_ex;
         2'd2: tgt = bus.i_pc_four_ex;
         default: tgt = bus.i_pred_pc;
      endcase
      if (bus.i_flush) begin
         m_pc = tgt; m_valid = 1'b0; m_pred = 1'b0;
         m_red = (m_red == 16'hFFFF) ? m_red : m_red + 16'd1;
      end else if (!bus.i_stall) begin
         if (m_valid) m_fetch = m_fetch + 32'd1;
         m_id_pc = m_pc;
         m_pc    = tgt;
         m_valid = 1'b1;
         m_pred  = (bus.i_pc_sel == 2'd3);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("imem_addr",   bus.o_imem_addr, m_pc);
      chk("pc_now",      bus.o_pc_now, m_pc);
      chk("pc_id",       bus.o_pc_id, m_id_pc);
      chk("pc_four_id",  bus.o_pc_four_id, m_id_pc + 32'd4);
      chk("valid_id",    {31'h0, bus.o_valid_id}, {31'h0, m_valid});
      chk("pred_id",     {31'h0, bus.o_pred_taken_id}, {31'h0, m_pred});
      chk("instr_id",    bus.o_instr_id, m_valid ? mem_word(m_id_pc) : NOP);
      chk("fetch_cnt",   bus.o_fetch_cnt, m_fetch);
      chk("redirect_cnt", {16'h0, bus.o_redirect_cnt}, {16'h0, m_red});
   endtask

   task automatic drive(input logic fl, input logic st, input logic [1:0] sel,
                        input logic [31:0] tgt);
      bus.i_flush = fl; bus.i_stall = st; bus.i_pc_sel = sel;
      bus.i_alu_ex = 32'hA1A1_0000; bus.i_pc_four_ex = 32'hB2B2_0000; bus.i_pred_pc = 32'hC3C3_0000;
      case (sel)
         2'd1: bus.i_alu_ex = tgt;
         2'd2: bus.i_pc_four_ex = tgt;
         2'd3: bus.i_pred_pc = tgt;
         default: ;
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   typedef struct {
      logic        fl;
      logic        st;
      logic [1:0]  sel;
      logic [31:0] tgt;
      logic [31:0] e_now;
      logic [31:0] e_id;
      logic        e_v;
      logic        e_p;
   } vec_t;

   vec_t vecs [14];

   initial begin
      logic [31:0] fc_before;
      int          guard;

      vecs[0]  = '{1'b0, 1'b0, 2'd0, 32'h0,         32'h104,       32'h100,       1'b1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 2'd1, 32'h200,       32'h200,       32'h100,       1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 2'd3, 32'h400,       32'h400,       32'h200,       1'b1, 1'b1};
      vecs[3]  = '{1'b0, 1'b0, 2'd3, 32'h500,       32'h500,       32'h400,       1'b1, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 2'd2, 32'h300,       32'h300,       32'h500,       1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 2'd2, 32'h2C8,       32'h2C8,       32'h500,       1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 2'd0, 32'h0,         32'h2CC,       32'h2C8,       1'b1, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h2C8,       1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         32'hFFFF_FFFC, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 2'd0, 32'h0,         32'h4,         32'hFFFF_FFFC, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 2'd3, 32'h700,       32'h700,       32'hFFFF_FFFC, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 2'd0, 32'h0,         32'h700,       32'hFFFF_FFFC, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 2'd1, 32'h703,       32'h703,       32'h700,       1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 2'd0, 32'h0,         32'h707,       32'h703,       1'b1, 1'b0};

      model_reset();
      drive(1'b0, 1'b0, 2'd0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_instr", bus.o_instr_id, NOP);
      chk("rst_valid", {31'h0, bus.o_valid_id}, 32'h0);
      chk("rst_pc_four_id", bus.o_pc_four_id, 32'h4);
      check_model();
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].fl, vecs[i].st, vecs[i].sel, vecs[i].tgt);
         step();
         chk($sformatf("vec%0d_now", i), bus.o_pc_now, vecs[i].e_now);
         chk($sformatf("vec%0d_id", i), bus.o_pc_id, vecs[i].e_id);
         chk($sformatf("vec%0d_valid", i), {31'h0, bus.o_valid_id}, {31'h0, vecs[i].e_v});
         chk($sformatf("vec%0d_pred", i), {31'h0, bus.o_pred_taken_id}, {31'h0, vecs[i].e_p});
      end

      // Stall hold over three cycles while memory returns other words.
      drive(1'b1, 1'b0, 2'd1, 32'h600);
      step();
      drive(1'b0, 1'b0, 2'd0, 32'h0);
      step();
      chk("hold_pre_instr", bus.o_instr_id, 32'hDEAD_BEEF);
      fc_before = bus.o_fetch_cnt;
      drive(1'b0, 1'b1, 2'd0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("hold_instr", bus.o_instr_id, 32'hDEAD_BEEF);
         chk("hold_pc_now", bus.o_pc_now, 32'h604);
         chk("hold_fetch_cnt", bus.o_fetch_cnt, fc_before);
      end

      // Flush while stalled: flush wins and the hold buffer is dropped.
      drive(1'b1, 1'b1, 2'd1, 32'h500);
      step();
      chk("fls_pc_now", bus.o_pc_now, 32'h500);
      chk("fls_instr", bus.o_instr_id, NOP);
      drive(1'b0, 1'b0, 2'd0, 32'h0);
      step();
      chk("fls_next_instr", bus.o_instr_id, mem_word(32'h500));

      // Reset asserted mid-stall with a captured hold word.
      drive(1'b0, 1'b1, 2'd0, 32'h0);
      step();
      step();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_model();
      chk("mrst_instr", bus.o_instr_id, NOP);
      drive(1'b0, 1'b0, 2'd0, 32'h0);
      step();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("mrst_pc_id", bus.o_pc_id, RST_PC);
      chk("mrst_pc_now", bus.o_pc_now, RST_PC + 32'd4);

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         bus.i_flush      = ($urandom_range(0, 99) < 15);
         bus.i_stall      = ($urandom_range(0, 99) < 30);
         bus.i_pc_sel     = 2'($urandom_range(0, 3));
         bus.i_alu_ex     = $urandom;
         bus.i_pc_four_ex = $urandom;
         bus.i_pred_pc    = $urandom;
         step();
      end

      // Drive the redirect counter to saturation, then flush once more.
      guard = 0;
      while (m_red != 16'hFFFF && guard < 70000) begin
         bus.i_flush  = 1'b1;
         bus.i_stall  = 1'($urandom_range(0, 1));
         bus.i_pc_sel = 2'($urandom_range(0, 3));
         @(posedge clk);
         model_edge();
         #1;
         guard++;
      end
      chk("sat_guard", {31'h0, (guard < 70000)}, 32'h1);
      check_model();
      drive(1'b1, 1'b0, 2'd2, 32'h800);
      step();
      chk("sat_redirect", {16'h0, bus.o_redirect_cnt}, 32'h0000_FFFF);
      chk("sat_pc_now", bus.o_pc_now, 32'h800);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
